combo_streak_tracker: RTL and testbench

//   Parametrised combo engine for Whac-A-Mole scoring. Counts consecutive successful hits,

---
 rtl/combo_pkg.sv | 21 ++
 rtl/combo_timeout_timer.sv | 33 +++
 rtl/combo_streak_tracker.sv | 101 ++++++++++
 tb/tb_combo_streak_tracker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/combo_pkg.sv
// Shared types, default constants and sizing helper for the combo streak tracker.
package combo_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam int CLK_HZ            = 50_000_000;
    localparam int TIMEOUT_SECONDS   = 3;
    localparam int DEFAULT_TIMEOUT   = CLK_HZ * TIMEOUT_SECONDS;
    localparam int DEFAULT_MAX_COMBO = 99;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/combo_timeout_timer.sv
// Loadable down-counter that flags expiry at zero; clear outranks load, load outranks count.
// One-cycle update latency, no backpressure.
module combo_timeout_timer
    import combo_pkg::*;
#(
    parameter int CYCLES = DEFAULT_TIMEOUT
)(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (clog2(CYCLES) < 1) ? 1 : clog2(CYCLES);
    localparam logic [TW-1:0] LOAD_VAL = TW'(CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (enable && count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/combo_streak_tracker.sv
// Whac-A-Mole combo engine: saturating streak, tiered multiplier, session best, break pulse.
// State and outputs update one cycle after the input pulse; pulses are always accepted.
module combo_streak_tracker
    import combo_pkg::*;
#(
    parameter int WIDTH          = 7,
    parameter int MAX_COMBO      = DEFAULT_MAX_COMBO,
    parameter int HIT_INC        = 1,
    parameter int CLEAR_INC      = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int TIER_STEP      = 10,
    parameter int MAX_MULT       = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             new_round,
    input  logic             pause,
    input  logic             miss,
    input  logic             hit,
    input  logic             full_clear,
    output logic [WIDTH-1:0] combo_val,
    output logic [WIDTH-1:0] best_combo,
    output logic [2:0]       multiplier,
    output logic             combo_break,
    output logic             timer_active
);

    if (MAX_COMBO >= (1 << WIDTH)) begin : g_bad_max_combo
        $error("MAX_COMBO must be below 2**WIDTH");
    end
    if (MAX_MULT < 1 || MAX_MULT > 7) begin : g_bad_max_mult
        $error("MAX_MULT must be in 1..7");
    end

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_COMBO);

    state_t         state;
    logic           expired;
    logic           hit_eff;
    logic           timeout_fire;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] next_combo;
    logic [WIDTH-1:0] tier;
    logic [WIDTH:0] mult_raw;

    assign hit_eff      = hit && !miss && !new_round;
    assign timeout_fire = (state == ACTIVE) && !pause && expired;

    // Extra headroom bit so the sum saturates instead of wrapping.
    assign sum        = {1'b0, combo_val} + (full_clear ? (WIDTH+1)'(CLEAR_INC) : (WIDTH+1)'(HIT_INC));
    assign next_combo = (sum > MAX_W) ? MAX_W[WIDTH-1:0] : sum[WIDTH-1:0];

    if (TIMEOUT_CYCLES != 0) begin : g_timer
        combo_timeout_timer #(
            .CYCLES (TIMEOUT_CYCLES)
        ) u_timer (
            .clk     (clk),
            .reset   (reset),
            .load    (hit_eff),
            .clear   (new_round || miss || (timeout_fire && !hit)),
            .enable  ((state == ACTIVE) && !pause),
            .expired (expired)
        );
    end else begin : g_no_timer
        assign expired = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            combo_val   <= '0;
            best_combo  <= '0;
            combo_break <= 1'b0;
        end else begin
            combo_break <= 1'b0;
            if (new_round) begin
                state     <= IDLE;
                combo_val <= '0;
            end else if (miss) begin
                state       <= IDLE;
                combo_val   <= '0;
                combo_break <= (combo_val != '0);
            end else if (hit) begin
                state      <= ACTIVE;
                combo_val  <= next_combo;
                best_combo <= (next_combo > best_combo) ? next_combo : best_combo;
            end else if (timeout_fire) begin
                state       <= IDLE;
                combo_val   <= '0;
                combo_break <= 1'b1;
            end
        end
    end

    assign tier       = combo_val / WIDTH'(TIER_STEP);
    assign mult_raw   = {1'b0, tier} + (WIDTH+1)'(1);
    assign multiplier = (mult_raw > (WIDTH+1)'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];

    assign timer_active = (state == ACTIVE) && !pause && (TIMEOUT_CYCLES != 0);

endmodule

// File: tb/tb_combo_streak_tracker.sv
// Directed bench for combo_streak_tracker with a 20-cycle timeout.
module tb_combo_streak_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_round = 1'b0;
    logic       pause = 1'b0;
    logic       miss = 1'b0;
    logic       hit = 1'b0;
    logic       full_clear = 1'b0;
    logic [6:0] combo_val;
    logic [6:0] best_combo;
    logic [2:0] multiplier;
    logic       combo_break;
    logic       timer_active;

    int n_cmp = 0;
    int n_err = 0;

    combo_streak_tracker #(
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .new_round    (new_round),
        .pause        (pause),
        .miss         (miss),
        .hit          (hit),
        .full_clear   (full_clear),
        .combo_val    (combo_val),
        .best_combo   (best_combo),
        .multiplier   (multiplier),
        .combo_break  (combo_break),
        .timer_active (timer_active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_hit(input logic fc);
        hit = 1'b1;
        full_clear = fc;
        tick(1);
        hit = 1'b0;
        full_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    int breaks;

    initial begin
        // Reset state
        do_reset();
        chk("rst_combo", 32'(combo_val), 0);
        chk("rst_best", 32'(best_combo), 0);
        chk("rst_mult", 32'(multiplier), 1);
        chk("rst_break", 32'(combo_break), 0);
        chk("rst_tact", 32'(timer_active), 0);

        // 1: twelve hits, five cycles apart
        breaks = 0;
        for (int i = 1; i <= 12; i++) begin
            pulse_hit(1'b0);
            if (i == 9)  chk("t1_mult_at9", 32'(multiplier), 1);
            if (i == 10) chk("t1_mult_at10", 32'(multiplier), 2);
            for (int j = 0; j < 4; j++) begin
                if (combo_break) breaks++;
                tick(1);
            end
        end
        chk("t1_combo", 32'(combo_val), 12);
        chk("t1_mult", 32'(multiplier), 2);
        chk("t1_best", 32'(best_combo), 12);
        chk("t1_nobreak", 32'(breaks), 0);
        chk("t1_tact", 32'(timer_active), 1);

        // 2: climb to 98 with clear hits, then saturate at 99
        for (int i = 0; i < 43; i++) pulse_hit(1'b1);
        chk("t2_combo98", 32'(combo_val), 98);
        pulse_hit(1'b1);
        chk("t2_combo_sat", 32'(combo_val), 99);
        pulse_hit(1'b0);
        chk("t2_combo_hold", 32'(combo_val), 99);
        chk("t2_mult", 32'(multiplier), 4);
        chk("t2_best", 32'(best_combo), 99);

        // 3: simultaneous miss and hit at combo 5
        do_reset();
        for (int i = 0; i < 5; i++) pulse_hit(1'b0);
        chk("t3_pre", 32'(combo_val), 5);
        miss = 1'b1;
        hit = 1'b1;
        tick(1);
        miss = 1'b0;
        hit = 1'b0;
        chk("t3_combo", 32'(combo_val), 0);
        chk("t3_break", 32'(combo_break), 1);
        chk("t3_best", 32'(best_combo), 5);
        tick(1);
        chk("t3_break_end", 32'(combo_break), 0);

        // 4: timeout after 20 idle cycles
        for (int i = 0; i < 3; i++) pulse_hit(1'b0);
        tick(19);
        chk("t4_before_exp", 32'(combo_val), 3);
        chk("t4_nobreak_yet", 32'(combo_break), 0);
        tick(1);
        chk("t4_exp_combo", 32'(combo_val), 0);
        chk("t4_exp_break", 32'(combo_break), 1);
        tick(1);
        chk("t4_break_end", 32'(combo_break), 0);

        // 4b: pause freezes the countdown
        for (int i = 0; i < 3; i++) pulse_hit(1'b0);
        pause = 1'b1;
        tick(30);
        chk("t4p_paused_combo", 32'(combo_val), 3);
        chk("t4p_paused_tact", 32'(timer_active), 0);
        pause = 1'b0;
        tick(19);
        chk("t4p_pre_exp", 32'(combo_val), 3);
        chk("t4p_tact", 32'(timer_active), 1);
        tick(1);
        chk("t4p_exp_combo", 32'(combo_val), 0);
        chk("t4p_exp_break", 32'(combo_break), 1);

        // 5: hit on the expiry cycle wins
        tick(1);
        pulse_hit(1'b0);
        tick(19);
        pulse_hit(1'b0);
        chk("t5_combo", 32'(combo_val), 2);
        chk("t5_nobreak", 32'(combo_break), 0);
        tick(19);
        chk("t5_reloaded", 32'(combo_val), 2);
        tick(1);
        chk("t5_exp_break", 32'(combo_break), 1);

        // 5b: miss while idle gives no pulse
        miss = 1'b1;
        tick(1);
        miss = 1'b0;
        chk("t5_idle_miss_break", 32'(combo_break), 0);
        tick(1);
        chk("t5_idle_miss_break2", 32'(combo_break), 0);

        // 6: new_round keeps best, reset clears it
        for (int i = 0; i < 7; i++) pulse_hit(1'b0);
        new_round = 1'b1;
        tick(1);
        new_round = 1'b0;
        chk("t6_combo", 32'(combo_val), 0);
        chk("t6_best", 32'(best_combo), 7);
        chk("t6_break", 32'(combo_break), 0);
        chk("t6_tact", 32'(timer_active), 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_best", 32'(best_combo), 0);
        chk("t6_rst_mult", 32'(multiplier), 1);
        chk("t6_rst_break", 32'(combo_break), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
